// File: rtl/exe_mem_pipe_reg_pkg.sv
// Shared definitions for the pipeline stage registers: handshake state
// encoding, default field widths and the payload width helper.
package exe_mem_pipe_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEST_W = 4;

    // Control flags, data-wide fields and the destination index, packed flat.
    function automatic int payload_w(input int ctrl_bits, input int data_w,
                                     input int data_fields, input int dest_w);
        return ctrl_bits + data_fields * data_w + dest_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready stage register with optional skid entry and flush.
// Accepted payload appears one cycle later; SKID=1 gives a registered ready.
module pipe_skid_buf
    import exe_mem_pipe_reg_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    pipe_state_t  r_state;
    pipe_state_t  w_state_nxt;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_in_rdy;
    logic         w_acc;
    logic         w_iss;
    logic         w_ld_main;
    logic         w_ld_skid;
    logic         w_main_from_skid;

    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main;
    // Without a skid slot a full register can only take data if it drains now.
    assign in_ready  = SKID ? r_in_rdy : (!out_valid || out_ready);
    assign w_acc     = in_valid && in_ready && !flush;
    assign w_iss     = out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_ld_main        = 1'b0;
        w_ld_skid        = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt = ST_FULL;
                    w_ld_main   = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_acc && w_iss) begin
                    w_ld_main = 1'b1;
                end else if (w_acc) begin
                    w_state_nxt = ST_SKID;
                    w_ld_skid   = 1'b1;
                end else if (w_iss) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_iss) begin
                    w_state_nxt      = ST_FULL;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Squash wins; the main register keeps its last contents.
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_main   <= '0;
            r_skid   <= '0;
            r_in_rdy <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_in_rdy <= (w_state_nxt != ST_SKID);
            if (w_ld_main) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= in_data;
            end
        end
    end

    always_comb begin
        case (r_state)
            ST_FULL: occupancy = 2'd1;
            ST_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register: packs EXE results into a skid-buffered stage
// and presents inert control bits to MEM whenever no entry is valid.
module exe_mem_pipe_reg
    import exe_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEST_W = DEF_DEST_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] st_val,
    output logic [DEST_W-1:0] dest,
    output logic [1:0]        occupancy
);

    localparam int PW = payload_w(3, DATA_W, 2, DEST_W);

    logic [PW-1:0] w_in_pld;
    logic [PW-1:0] w_out_pld;
    logic          w_wb_en;
    logic          w_mem_r_en;
    logic          w_mem_w_en;

    assign w_in_pld = {wb_en_in, mem_r_en_in, mem_w_en_in,
                       alu_result_in, st_val_in, dest_in};

    pipe_skid_buf #(
        .W    (PW),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_pld),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_pld),
        .occupancy (occupancy)
    );

    assign {w_wb_en, w_mem_r_en, w_mem_w_en, alu_result, st_val, dest} = w_out_pld;

    // A bubble must never write the register file or touch memory.
    assign wb_en    = w_wb_en    && out_valid;
    assign mem_r_en = w_mem_r_en && out_valid;
    assign mem_w_en = w_mem_w_en && out_valid;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Bench for exe_mem_pipe_reg: SKID=1 and SKID=0 instances share stimulus and
// are each compared every cycle against a queue-based reference model.
module tb_exe_mem_pipe_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [70:0] din;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_result_in, st_val_in;
    logic [3:0]  dest_in;

    assign {wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, st_val_in, dest_in} = din;

    logic        in_ready_s1, out_valid_s1, wb_en_s1, mem_r_en_s1, mem_w_en_s1;
    logic [31:0] alu_result_s1, st_val_s1;
    logic [3:0]  dest_s1;
    logic [1:0]  occupancy_s1;
    logic        in_ready_s0, out_valid_s0, wb_en_s0, mem_r_en_s0, mem_w_en_s0;
    logic [31:0] alu_result_s0, st_val_s0;
    logic [3:0]  dest_s0;
    logic [1:0]  occupancy_s0;

    exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(4), .SKID(1'b1)) dut_s1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s1),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .out_valid(out_valid_s1), .out_ready(out_ready),
        .wb_en(wb_en_s1), .mem_r_en(mem_r_en_s1), .mem_w_en(mem_w_en_s1),
        .alu_result(alu_result_s1), .st_val(st_val_s1), .dest(dest_s1),
        .occupancy(occupancy_s1)
    );

    exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(4), .SKID(1'b0)) dut_s0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s0),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .out_valid(out_valid_s0), .out_ready(out_ready),
        .wb_en(wb_en_s0), .mem_r_en(mem_r_en_s0), .mem_w_en(mem_w_en_s0),
        .alu_result(alu_result_s0), .st_val(st_val_s0), .dest(dest_s0),
        .occupancy(occupancy_s0)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: an ordered queue of held entries per instance plus the value
    // last shown on the data outputs (kept while empty).
    logic [70:0] q1[$];
    logic [70:0] q0[$];
    logic [70:0] held1 = '0;
    logic [70:0] held0 = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [70:0] exp_pld(input bit v, input logic [70:0] h);
        return {(v ? h[70:68] : 3'b000), h[67:0]};
    endfunction

    function automatic logic [70:0] rnd_pld();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[70:0];
    endfunction

    function automatic logic [70:0] mk(input logic [2:0] c, input logic [31:0] a,
                                       input logic [31:0] s, input logic [3:0] d);
        return {c, a, s, d};
    endfunction

    task automatic cyc(input bit r, input bit fl, input bit iv, input bit ordy,
                       input logic [70:0] d, input bit do_chk);
        bit a1, a0, i1, i0, v1, v0;
        rst = r; flush = fl; in_valid = iv; out_ready = ordy; din = d;
        @(negedge clk);
        v1 = (q1.size() > 0);
        v0 = (q0.size() > 0);
        if (do_chk) begin
            chk("s1_vld_rdy_occ", {125'd0, out_valid_s1, in_ready_s1, occupancy_s1},
                {125'd0, v1, (q1.size() < 2), 2'(q1.size())});
            chk("s1_payload", {57'd0, wb_en_s1, mem_r_en_s1, mem_w_en_s1,
                               alu_result_s1, st_val_s1, dest_s1},
                {57'd0, exp_pld(v1, held1)});
            chk("s0_vld_rdy_occ", {125'd0, out_valid_s0, in_ready_s0, occupancy_s0},
                {125'd0, v0, (!v0 || ordy), 2'(q0.size())});
            chk("s0_payload", {57'd0, wb_en_s0, mem_r_en_s0, mem_w_en_s0,
                               alu_result_s0, st_val_s0, dest_s0},
                {57'd0, exp_pld(v0, held0)});
        end
        @(posedge clk);
        if (r) begin
            q1.delete(); q0.delete();
            held1 = '0; held0 = '0;
        end else if (fl) begin
            q1.delete(); q0.delete();
        end else begin
            a1 = iv && (q1.size() < 2);
            i1 = v1 && ordy;
            if (i1) void'(q1.pop_front());
            if (a1) q1.push_back(d);
            if (q1.size() > 0) held1 = q1[0];
            a0 = iv && (!v0 || ordy);
            i0 = v0 && ordy;
            if (i0) void'(q0.pop_front());
            if (a0) q0.push_back(d);
            if (q0.size() > 0) held0 = q0[0];
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;

        // Reset held two cycles while EXE keeps presenting data.
        cyc(1, 0, 1, 1, rnd_pld(), 0);
        cyc(1, 0, 1, 1, rnd_pld(), 1);

        // Back-to-back streaming with MEM always ready.
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 1, 1, mk(3'b100, 32'h1000 + i, $urandom(), 4'(i)), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);

        // Stall: A then B, MEM not ready for three cycles, then drain.
        cyc(0, 0, 1, 0, mk(3'b010, 32'hAAAA0001, 32'h11, 4'h1), 1);
        cyc(0, 0, 1, 0, mk(3'b001, 32'hBBBB0002, 32'h22, 4'h2), 1);
        cyc(0, 0, 0, 0, rnd_pld(), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, rnd_pld(), 1);

        // Flush while two entries are held, with a concurrent input.
        cyc(0, 0, 1, 0, mk(3'b111, 32'hC0DE0001, 32'h33, 4'h5), 1);
        cyc(0, 0, 1, 0, mk(3'b111, 32'hC0DE0002, 32'h44, 4'h6), 1);
        cyc(0, 1, 1, 0, mk(3'b111, 32'hDEAD0003, 32'h55, 4'h9), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);

        // Single-entry stall, then accept and issue together (dest 3 -> 7).
        cyc(0, 0, 1, 1, mk(3'b100, 32'h3333, 32'h0, 4'h3), 1);
        cyc(0, 0, 0, 0, rnd_pld(), 1);
        cyc(0, 0, 1, 1, mk(3'b100, 32'h7777, 32'h0, 4'h7), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);

        // Flush and reset together: reset wins and zeroes the payload.
        cyc(0, 0, 1, 0, mk(3'b111, 32'hFFFF0000, 32'hFFFF, 4'hF), 1);
        cyc(0, 0, 1, 0, mk(3'b111, 32'hFFFF0001, 32'hFFFF, 4'hE), 1);
        cyc(1, 1, 1, 0, rnd_pld(), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);

        // Random valid/ready/flush with occasional reset.
        for (int i = 0; i < 10000; i++)
            cyc(($urandom_range(499) == 0), ($urandom_range(19) == 0),
                ($urandom_range(9) < 7), ($urandom_range(9) < 6), rnd_pld(), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);
        cyc(0, 0, 0, 1, rnd_pld(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
